dac_ramp_ctrl: RTL and testbench
================================

Name: dac_ramp_ctrl

Overview:
- Slew-limited setpoint controller that sits in front of the delta-sigma `dac` and drives its `data` input.
- Arbitrates round-robin among NREQ requesters, each offering a target code over a valid/ready handshake.
- Ramps the DAC code from its current value to the accepted target in programmable steps at a programmable tick rate.
- Signals completion so firmware-side logic (angle/ignition timing blocks) can sequence analog setpoints without glitching the DAC output.

Parameters:
WIDTH, 8, DAC code width; must match the `dac` instance WIDTH
NREQ, 2, number of requesters (1..8)
DIV_WIDTH, 16, width of the tick prescaler

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_data  input  NREQ*WIDTH  per-requester target code; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  per-requester accept strobe
div  input  DIV_WIDTH  prescaler: one ramp tick every div+1 clocks
step  input  WIDTH  code increment per tick; 0 is treated as 1
dac_data  output  WIDTH  code driven to `dac.data`
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse when a ramp reaches target
grant_id  output  $clog2(NREQ) (min 1)  index of the last accepted requester

Behaviour:
- Reset (async, rst=1) sets the following, holding them while rst=1:
  - state=IDLE
  - dac_data=0, grant_id=0, done=0, busy=0, req_ready=0
  - rr_ptr=0, prescaler cnt=0
- Only accepted state is updated at the clock edge; no output changes on the clock edge while rst=1.
- FSM states are IDLE, RAMP and DONE.
- IDLE:
  - Search for the first asserted req_valid, starting at index rr_ptr and wrapping modulo NREQ.
  - If one is found at index k:
    - req_ready[k]=1 in that same cycle (combinational, IDLE only). All other ready bits are 0.
    - At the edge: target<=req_data[k], div_l<=div, step_l<=max(step,1), grant_id<=k, rr_ptr<=(k+1) mod NREQ, cnt<=0, state<=RAMP.
  - If none is found, stay in IDLE.
  - req_ready is never high outside IDLE. Requests arriving in RAMP/DONE wait; valid must be held until ready.
- RAMP:
  - busy=1. cnt increments each clock.
  - Tick when cnt==div_l; the tick also sets cnt<=0.
  - Target check: if dac_data==target at any RAMP cycle, go to DONE next edge without a tick. A zero-distance request therefore spends exactly 1 cycle in RAMP.
  - On tick, compute diff = target - dac_data in WIDTH+1 signed bits (no wrap):
    - |diff| <= step_l: dac_data<=target.
    - Otherwise dac_data moves by ±step_l toward target.
  - Result never overshoots, never wraps past 0 or 2^WIDTH-1.
  - div/step input changes during RAMP have no effect; the latched copies are used.
- DONE: done=1 for exactly one cycle, busy=1, state<=IDLE next edge. A new grant can occur the cycle after DONE.
- Latency:
  - Accept edge to first dac_data change: div_l+1 clocks.
  - Total ticks = ceil(|target - start| / step_l).
- dac_data is registered and changes only on tick edges (or reset).
- Multiple simultaneous valids: exactly one is granted per IDLE visit, in round-robin order.
- rst asserted mid-ramp:
  - Immediate return to the reset values.
  - The in-flight request is dropped, with no done pulse.
  - The requester must re-present it.
- NREQ=1: rr_ptr is constant 0; grant_id is 1 bit wide, always 0.

Test Plan:
- Reset, then requester 0 valid with data=0x40, div=3, step=0x10 -> ready[0] high 1 cycle. dac_data takes 0x10,0x20,0x30,0x40 at 4-clock intervals, then done pulses once. busy drops the cycle after done.
- From dac_data=0x40, request 0x05 with div=0, step=0x10 -> dac_data goes 0x30,0x20,0x10,0x05 on consecutive clocks; no underflow or wrap.
- req_valid=2'b11 held continuously, data0=0x80, data1=0x20, step=0xFF -> grants alternate 0,1,0,1 (grant_id). dac_data alternates 0x80/0x20, one tick per grant.
- step=0, target 0x03 from 0x00, div=1 -> three single-code increments, each 2 clocks apart. A div change mid-ramp does not alter the spacing.
- Request equal to the current dac_data -> RAMP 1 cycle, done pulse, no dac_data change.
- rst pulsed mid-ramp at dac_data=0x30 -> dac_data=0, busy=0 asynchronously, no done pulse. The next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/dac_ramp_if.sv
// -----------------------------------------------------------------------------
// dac_ramp_if
// Request bundle between setpoint requesters and dac_ramp_ctrl.
//   req_valid [NREQ]        : per-requester request valid (held until ready)
//   req_data  [NREQ*WIDTH]  : per-requester target code, requester i in
//                             bits [i*WIDTH +: WIDTH]
//   req_ready [NREQ]        : per-requester accept strobe from the controller
// master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface dac_ramp_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/dac_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// dac_ramp_ctrl
// Slew-limited setpoint controller in front of the delta-sigma dac. Accepts one
// target code at a time from NREQ requesters (round-robin), then walks the DAC
// code toward it by step_l every div_l+1 clocks, pulsing done on arrival.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req_if    : requester bundle (slave side): req_valid/req_data/req_ready
//   div       : prescaler, one ramp tick every div+1 clocks (latched on accept)
//   step      : code increment per tick, 0 behaves as 1 (latched on accept)
//   dac_data  : code driven to the dac data input
//   busy      : high while a request is being serviced (RAMP or DONE)
//   done      : one-cycle pulse when the ramp reaches its target
//   grant_id  : index of the most recently accepted requester
// -----------------------------------------------------------------------------
module dac_ramp_ctrl #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 2,
    parameter int DIV_WIDTH = 16,
    localparam int GID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dac_ramp_if.slave            req_if,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [WIDTH-1:0]     step,
    output logic [WIDTH-1:0]     dac_data,
    output logic                 busy,
    output logic                 done,
    output logic [GID_W-1:0]     grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_DONE
    } state_t;

    state_t               state_reg;
    logic [GID_W-1:0]     rr_ptr_reg;
    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [DIV_WIDTH-1:0] div_l_reg;
    logic [WIDTH-1:0]     step_l_reg;
    logic [WIDTH-1:0]     target_reg;
    logic [WIDTH-1:0]     dac_data_reg;
    logic [GID_W-1:0]     grant_id_reg;

    // ---------------------------------------------------------------------
    // Round-robin search. Requests are rotated so that offset 0 is rr_ptr;
    // the lowest set bit of the rotated vector is the winner.
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] req_word  [NREQ];
    logic [GID_W-1:0] cand_idx  [NREQ];
    logic [NREQ-1:0]  rot_valid;
    logic [NREQ-1:0]  first_hit;
    logic [GID_W-1:0] pick_idx;
    logic [GID_W-1:0] rr_next;
    logic             req_found;
    logic             grant_fire;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_word[gi]  = req_if.req_data[gi*WIDTH +: WIDTH];
            assign cand_idx[gi]  = GID_W'((int'(rr_ptr_reg) + gi) % NREQ);
            assign rot_valid[gi] = req_if.req_valid[cand_idx[gi]];
            // Ready is combinational from the search and only ever in IDLE.
            assign req_if.req_ready[gi] = grant_fire && (pick_idx == GID_W'(gi));
        end
    endgenerate

    // Isolate the lowest set bit (x & -x): exactly one winner.
    assign first_hit  = rot_valid & (~rot_valid + NREQ'(1));
    assign req_found  = |rot_valid;
    assign grant_fire = !rst && (state_reg == ST_IDLE) && req_found;

    always_comb begin
        pick_idx = '0;
        for (int o = 0; o < NREQ; o++) begin
            if (first_hit[o]) begin
                pick_idx = pick_idx | cand_idx[o];
            end
        end
    end

    assign rr_next = (pick_idx == GID_W'(NREQ - 1)) ? '0 : pick_idx + GID_W'(1);

    // ---------------------------------------------------------------------
    // Tick arithmetic: signed distance in WIDTH+1 bits so it never wraps.
    // A full step is only taken when the distance exceeds it, so the
    // add/subtract below cannot overshoot or wrap.
    // ---------------------------------------------------------------------
    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]        mag;
    logic [WIDTH-1:0]      tick_next;

    always_comb begin
        diff = $signed({1'b0, target_reg}) - $signed({1'b0, dac_data_reg});
        mag  = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        if (mag <= {1'b0, step_l_reg}) begin
            tick_next = target_reg;
        end else if (diff[WIDTH]) begin
            tick_next = dac_data_reg - step_l_reg;
        end else begin
            tick_next = dac_data_reg + step_l_reg;
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            cnt_reg      <= '0;
            div_l_reg    <= '0;
            step_l_reg   <= '0;
            target_reg   <= '0;
            dac_data_reg <= '0;
            grant_id_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_found) begin
                        target_reg   <= req_word[pick_idx];
                        div_l_reg    <= div;
                        step_l_reg   <= (step == '0) ? WIDTH'(1) : step;
                        grant_id_reg <= pick_idx;
                        rr_ptr_reg   <= rr_next;
                        cnt_reg      <= '0;
                        state_reg    <= ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    // Arrival check takes priority over a tick, so a
                    // zero-distance request leaves after one RAMP cycle.
                    if (dac_data_reg == target_reg) begin
                        state_reg <= ST_DONE;
                    end else if (cnt_reg == div_l_reg) begin
                        cnt_reg      <= '0;
                        dac_data_reg <= tick_next;
                    end else begin
                        cnt_reg <= cnt_reg + DIV_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign dac_data = dac_data_reg;
    assign grant_id = grant_id_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_dac_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dac_ramp_ctrl
// Directed bench for dac_ramp_ctrl (WIDTH=8, NREQ=2, DIV_WIDTH=16). Each task
// drives one scenario and checks its own hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_dac_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] div;
    logic [7:0]  step;
    logic [7:0]  dac_data;
    logic        busy;
    logic        done;
    logic [0:0]  grant_id;

    int tests_run    = 0;
    int tests_failed = 0;

    dac_ramp_if #(.WIDTH(8), .NREQ(2)) bus ();

    dac_ramp_ctrl #(.WIDTH(8), .NREQ(2), .DIV_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_if   (bus),
        .div      (div),
        .step     (step),
        .dac_data (dac_data),
        .busy     (busy),
        .done     (done),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation results, filled by observe().
    int chg_val[$];
    int chg_cyc[$];
    int done_cnt;
    int done_cyc;
    int idle_cyc;
    bit timed_out;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request on requester k, report ready seen before the accept
    // edge, then let the accept edge pass and withdraw valid.
    task automatic request(input int k, input logic [7:0] data, input logic [15:0] d,
                           input logic [7:0] s, output logic [1:0] rdy_seen);
        bus.req_valid = (k == 1) ? 2'b10 : 2'b01;
        if (k == 1) bus.req_data[15:8] = data;
        else        bus.req_data[7:0]  = data;
        div  = d;
        step = s;
        #1;
        rdy_seen = bus.req_ready;
        $display("[TB] req%0d target=%h div=%0d step=%h ready=%b from=%h", k, data, d, s, rdy_seen, dac_data);
        cyc();
        bus.req_valid = 2'b00;
    endtask

    // Follow a ramp from the accept edge (cycle 0) until busy drops.
    task automatic observe(input int max_c, input int div_at, input logic [15:0] new_div);
        logic [7:0] prev;
        prev = dac_data;
        chg_val.delete();
        chg_cyc.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        idle_cyc  = -1;
        timed_out = 1'b1;
        for (int c = 1; c <= max_c; c++) begin
            cyc();
            if (dac_data !== prev) begin
                chg_val.push_back(int'(dac_data));
                chg_cyc.push_back(c);
                prev = dac_data;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == div_at) div = new_div;
            if (busy === 1'b0) begin
                idle_cyc  = c;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_data  = 16'h2010;
        div  = 16'd0;
        step = 8'h01;
        repeat (3) cyc();
        tests_run++; if (dac_data !== 8'h00) begin tests_failed++; $display("FAIL reset_dac got %h want 00", dac_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++; if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready got %b want 00", bus.req_ready); end
        tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("FAIL reset_gid got %b want 0", grant_id); end
        bus.req_valid = 2'b00;
        rst = 1'b0;
        cyc();
        $display("[TB] reset released");
    endtask

    task automatic test_ramp_up();
        logic [1:0] rdy;
        int exp_v[4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        int exp_c[4] = '{4, 8, 12, 16};
        request(0, 8'h40, 16'd3, 8'h10, rdy);
        tests_run++; if (rdy !== 2'b01) begin tests_failed++; $display("FAIL up_ready got %b want 01", rdy); end
        tests_run++; if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL up_ready_after got %b want 00", bus.req_ready); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL up_busy got %b want 1", busy); end
        tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("FAIL up_gid got %b want 0", grant_id); end
        observe(40, -1, 16'd0);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL up_timeout got busy stuck want idle by 40"); end
        tests_run++; if (chg_val.size() != 4) begin tests_failed++; $display("FAIL up_nchg got %0d want 4", chg_val.size()); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i >= chg_val.size() || chg_val[i] != exp_v[i] || chg_cyc[i] != exp_c[i]) begin
                tests_failed++;
                $display("FAIL up_step%0d got %h@%0d want %h@%0d", i,
                         (i < chg_val.size()) ? chg_val[i] : -1, (i < chg_cyc.size()) ? chg_cyc[i] : -1, exp_v[i], exp_c[i]);
            end
        end
        tests_run++; if (done_cnt != 1 || done_cyc != 17) begin tests_failed++; $display("FAIL up_done got %0d@%0d want 1@17", done_cnt, done_cyc); end
        tests_run++; if (idle_cyc != 18) begin tests_failed++; $display("FAIL up_idle got %0d want 18", idle_cyc); end
    endtask

    task automatic test_ramp_down();
        logic [1:0] rdy;
        int exp_v[4] = '{8'h30, 8'h20, 8'h10, 8'h05};
        request(0, 8'h05, 16'd0, 8'h10, rdy);
        tests_run++; if (rdy !== 2'b01) begin tests_failed++; $display("FAIL down_ready got %b want 01", rdy); end
        observe(40, -1, 16'd0);
        tests_run++; if (chg_val.size() != 4) begin tests_failed++; $display("FAIL down_nchg got %0d want 4", chg_val.size()); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i >= chg_val.size() || chg_val[i] != exp_v[i] || chg_cyc[i] != i + 1) begin
                tests_failed++;
                $display("FAIL down_step%0d got %h@%0d want %h@%0d", i,
                         (i < chg_val.size()) ? chg_val[i] : -1, (i < chg_cyc.size()) ? chg_cyc[i] : -1, exp_v[i], i + 1);
            end
        end
        tests_run++; if (done_cnt != 1 || done_cyc != 5 || idle_cyc != 6) begin tests_failed++; $display("FAIL down_done got %0d@%0d idle %0d want 1@5 idle 6", done_cnt, done_cyc, idle_cyc); end
    endtask

    // Both requesters held valid; rr_ptr is 1 after the previous grant to 0.
    task automatic test_back_to_back();
        int grants[$];
        int gids[$];
        int vals[$];
        int exp_g[4] = '{1, 0, 1, 0};
        int exp_v[4] = '{8'h20, 8'h80, 8'h20, 8'h80};
        logic [7:0] prev;
        int  seen;
        bit  pend;
        bit  stop;
        bit  finished;
        seen = 0; pend = 0; stop = 0; finished = 0;
        prev = dac_data;
        bus.req_data  = {8'h20, 8'h80};
        bus.req_valid = 2'b11;
        div  = 16'd0;
        step = 8'hFF;
        #1;
        for (int c = 0; c < 80; c++) begin
            if (pend) begin
                gids.push_back(int'(grant_id));
                pend = 0;
                if (seen == 4) begin
                    bus.req_valid = 2'b00;
                    stop = 1;
                end
            end
            if (bus.req_ready !== 2'b00) begin
                grants.push_back((bus.req_ready === 2'b10) ? 1 : ((bus.req_ready === 2'b01) ? 0 : 9));
                $display("[TB] b2b grant ready=%b dac=%h", bus.req_ready, dac_data);
                seen++;
                pend = 1;
            end
            if (dac_data !== prev) begin
                vals.push_back(int'(dac_data));
                prev = dac_data;
            end
            if (stop && busy === 1'b0) begin
                finished = 1;
                break;
            end
            cyc();
        end
        tests_run++; if (!finished) begin tests_failed++; $display("FAIL b2b_timeout got %0d grants want 4 then idle", seen); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i >= grants.size() || i >= gids.size() || i >= vals.size() ||
                grants[i] != exp_g[i] || gids[i] != exp_g[i] || vals[i] != exp_v[i]) begin
                tests_failed++;
                $display("FAIL b2b_grant%0d got req%0d gid%0d dac %h want req%0d gid%0d dac %h", i,
                         (i < grants.size()) ? grants[i] : -1, (i < gids.size()) ? gids[i] : -1,
                         (i < vals.size()) ? vals[i] : -1, exp_g[i], exp_g[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_step_zero();
        logic [1:0] rdy;
        int exp_c[3] = '{2, 4, 6};
        // Bring the code back to 0 first (one full step from 0x80).
        request(1, 8'h00, 16'd0, 8'hFF, rdy);
        observe(20, -1, 16'd0);
        tests_run++; if (dac_data !== 8'h00) begin tests_failed++; $display("FAIL s0_setup got %h want 00", dac_data); end
        // div is changed to 5 at cycle 1; latched div=1 must still apply.
        request(0, 8'h03, 16'd1, 8'h00, rdy);
        tests_run++; if (rdy !== 2'b01) begin tests_failed++; $display("FAIL s0_ready got %b want 01", rdy); end
        observe(40, 1, 16'd5);
        tests_run++; if (chg_val.size() != 3) begin tests_failed++; $display("FAIL s0_nchg got %0d want 3", chg_val.size()); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (i >= chg_val.size() || chg_val[i] != i + 1 || chg_cyc[i] != exp_c[i]) begin
                tests_failed++;
                $display("FAIL s0_step%0d got %h@%0d want %h@%0d", i,
                         (i < chg_val.size()) ? chg_val[i] : -1, (i < chg_cyc.size()) ? chg_cyc[i] : -1, i + 1, exp_c[i]);
            end
        end
        tests_run++; if (done_cnt != 1 || done_cyc != 7 || idle_cyc != 8) begin tests_failed++; $display("FAIL s0_done got %0d@%0d idle %0d want 1@7 idle 8", done_cnt, done_cyc, idle_cyc); end
    endtask

    task automatic test_zero_distance();
        logic [1:0] rdy;
        request(1, 8'h03, 16'd2, 8'h04, rdy);
        tests_run++; if (rdy !== 2'b10) begin tests_failed++; $display("FAIL zd_ready got %b want 10", rdy); end
        tests_run++; if (grant_id !== 1'b1) begin tests_failed++; $display("FAIL zd_gid got %b want 1", grant_id); end
        observe(20, -1, 16'd0);
        tests_run++; if (chg_val.size() != 0) begin tests_failed++; $display("FAIL zd_nchg got %0d want 0", chg_val.size()); end
        tests_run++; if (done_cnt != 1 || done_cyc != 1 || idle_cyc != 2) begin tests_failed++; $display("FAIL zd_done got %0d@%0d idle %0d want 1@1 idle 2", done_cnt, done_cyc, idle_cyc); end
        tests_run++; if (dac_data !== 8'h03) begin tests_failed++; $display("FAIL zd_dac got %h want 03", dac_data); end
    endtask

    task automatic test_reset_mid_ramp();
        logic [1:0] rdy;
        bit reached;
        int dones;
        reached = 0;
        dones = 0;
        // Grant to requester 0 leaves rr_ptr=1 before the reset.
        request(0, 8'h33, 16'd3, 8'h10, rdy);
        for (int c = 0; c < 40; c++) begin
            if (dac_data === 8'h23) begin
                reached = 1;
                break;
            end
            cyc();
        end
        tests_run++; if (!reached) begin tests_failed++; $display("FAIL mid_reach got %h want 23", dac_data); end
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] rst asserted mid-ramp");
        tests_run++; if (dac_data !== 8'h00) begin tests_failed++; $display("FAIL mid_dac got %h want 00", dac_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %b want 0", busy); end
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (done === 1'b1) dones++;
        end
        tests_run++; if (dones != 0 || done !== 1'b0) begin tests_failed++; $display("FAIL mid_done got %0d pulses want 0", dones); end
        rst = 1'b0;
        cyc();
        bus.req_data  = {8'h20, 8'h10};
        bus.req_valid = 2'b11;
        div  = 16'd0;
        step = 8'hFF;
        #1;
        tests_run++; if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL mid_rrptr got %b want 01", bus.req_ready); end
        cyc();
        bus.req_valid = 2'b00;
        tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("FAIL mid_gid got %b want 0", grant_id); end
        observe(20, -1, 16'd0);
        tests_run++; if (dac_data !== 8'h10 || timed_out) begin tests_failed++; $display("FAIL mid_regrant got %h want 10", dac_data); end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_data  = 16'h0000;
        div  = 16'd0;
        step = 8'h00;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_back_to_back();
        test_step_zero();
        test_zero_distance();
        test_reset_mid_ramp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
